// File: rtl/dcache_snoop_responder_pkg.sv
// Shared constants and types for the DCache snoop responder.
// Address split is {tag, set, line offset}; the line is returned as BEATS XLEN-wide words.
package dcache_snoop_responder_pkg;

  localparam int PADDR_SIZE = 32;
  localparam int XLEN       = 64;
  localparam int ID_W       = 4;
  localparam int WAYS       = 4;
  localparam int SETS       = 64;
  localparam int LINE_BYTES = 64;

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int SET_W  = $clog2(SETS);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int TAG    = PADDR_SIZE - SET_W - OFF_W;
  localparam int BEATS  = LINE_BYTES * 8 / XLEN;
  localparam int BEAT_W = $clog2(BEATS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TAG_REQ,
    S_TAG_CHK,
    S_DATA_REQ,
    S_DATA_RD,
    S_SEND
  } snoop_state_t;

  typedef logic [LINE_BYTES*8-1:0] line_t;

  typedef struct packed {
    logic [TAG-1:0] tag;
    logic           valid;
  } tagv_t;

endpackage

// File: rtl/dcache_snoop_responder_serializer.sv
// Holds one cache line and streams it on CD as ascending XLEN beats.
// A load restarts at beat 0; done pulses combinationally on the accepted last beat.
module snoop_line_serializer
  import dcache_snoop_responder_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  line_t           load_line,
  input  logic [ID_W-1:0] load_user,
  output logic            cd_valid,
  input  logic            cd_ready,
  output logic [XLEN-1:0] cd_data,
  output logic            cd_last,
  output logic [ID_W-1:0] cd_user,
  output logic            done
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  line_t             line_q;
  logic [BEAT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q   <= '0;
      cd_user  <= '0;
      cd_valid <= 1'b0;
      cnt      <= '0;
    end else if (load) begin
      line_q   <= load_line;
      cd_user  <= load_user;
      cd_valid <= 1'b1;
      cnt      <= '0;
    end else if (cd_valid && cd_ready) begin
      if (cnt == LAST_BEAT) begin
        cd_valid <= 1'b0;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Data and last are pure functions of held registers, so they stay put while stalled.
  assign cd_data = line_q[int'(cnt) * XLEN +: XLEN];
  assign cd_last = cd_valid && (cnt == LAST_BEAT);
  assign done    = cd_valid && cd_ready && cd_last;

endmodule

// File: rtl/dcache_snoop_responder.sv
// Snoop responder: tag lookup, then data array or writeback buffer read, then line return on CD.
// One snoop in flight; array port waits on arr_gnt with request outputs held stable.
module dcache_snoop_responder
  import dcache_snoop_responder_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ac_valid,
  output logic                      ac_ready,
  input  logic [PADDR_SIZE-1:0]     ac_addr,
  input  logic [ID_W-1:0]           ac_user,
  output logic                      cd_valid,
  input  logic                      cd_ready,
  output logic [XLEN-1:0]           cd_data,
  output logic                      cd_last,
  output logic [ID_W-1:0]           cd_user,
  output logic                      arr_req,
  input  logic                      arr_gnt,
  output logic                      arr_tag_en,
  output logic                      arr_data_en,
  output logic [SET_W-1:0]          arr_idx,
  output logic [WAY_W-1:0]          arr_way,
  input  logic [WAYS*(TAG+1)-1:0]   arr_tag_rdata,
  input  logic [LINE_BYTES*8-1:0]   arr_data_rdata,
  output logic [PADDR_SIZE-1:0]     wb_addr,
  input  logic                      wb_hit,
  input  logic [LINE_BYTES*8-1:0]   wb_data,
  output logic                      snoop_miss
);

  snoop_state_t     state;
  logic [TAG-1:0]   tag_q;
  logic [ID_W-1:0]  user_q;

  tagv_t [WAYS-1:0] tagv;
  logic             arr_hit;
  logic [WAY_W-1:0] hit_way;

  logic             ser_load;
  line_t            ser_line;
  logic             ser_done;

  assign tagv = arr_tag_rdata;

  // Descending scan so the lowest matching way is the one left standing.
  always_comb begin
    arr_hit = 1'b0;
    hit_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (tagv[i].valid && (tagv[i].tag == tag_q)) begin
        arr_hit = 1'b1;
        hit_way = WAY_W'(i);
      end
    end
  end

  assign ser_load = ((state == S_TAG_CHK) && !arr_hit) || (state == S_DATA_RD);
  assign ser_line = (state == S_DATA_RD) ? arr_data_rdata : (wb_hit ? wb_data : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      ac_ready    <= 1'b1;
      arr_req     <= 1'b0;
      arr_tag_en  <= 1'b0;
      arr_data_en <= 1'b0;
      arr_idx     <= '0;
      arr_way     <= '0;
      wb_addr     <= '0;
      tag_q       <= '0;
      user_q      <= '0;
      snoop_miss  <= 1'b0;
    end else begin
      snoop_miss <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ac_valid) begin
            wb_addr    <= ac_addr;
            tag_q      <= ac_addr[PADDR_SIZE-1 -: TAG];
            user_q     <= ac_user;
            arr_idx    <= ac_addr[OFF_W +: SET_W];
            ac_ready   <= 1'b0;
            arr_req    <= 1'b1;
            arr_tag_en <= 1'b1;
            state      <= S_TAG_REQ;
          end
        end
        S_TAG_REQ: begin
          if (arr_gnt) begin
            arr_req    <= 1'b0;
            arr_tag_en <= 1'b0;
            state      <= S_TAG_CHK;
          end
        end
        S_TAG_CHK: begin
          if (arr_hit) begin
            arr_way     <= hit_way;
            arr_req     <= 1'b1;
            arr_data_en <= 1'b1;
            state       <= S_DATA_REQ;
          end else begin
            snoop_miss <= !wb_hit;
            state      <= S_SEND;
          end
        end
        S_DATA_REQ: begin
          if (arr_gnt) begin
            arr_req     <= 1'b0;
            arr_data_en <= 1'b0;
            state       <= S_DATA_RD;
          end
        end
        S_DATA_RD: state <= S_SEND;
        S_SEND: begin
          if (ser_done) begin
            ac_ready <= 1'b1;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  snoop_line_serializer u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (ser_load),
    .load_line (ser_line),
    .load_user (user_q),
    .cd_valid  (cd_valid),
    .cd_ready  (cd_ready),
    .cd_data   (cd_data),
    .cd_last   (cd_last),
    .cd_user   (cd_user),
    .done      (ser_done)
  );

endmodule

// File: tb/tb_dcache_snoop_responder.sv
// Directed bench for dcache_snoop_responder: hits, wb hits, misses, grant stalls, CD backpressure, reset.
module tb_dcache_snoop_responder;

  logic          clk;
  logic          rst;
  logic          ac_valid;
  logic          ac_ready;
  logic [31:0]   ac_addr;
  logic [3:0]    ac_user;
  logic          cd_valid;
  logic          cd_ready;
  logic [63:0]   cd_data;
  logic          cd_last;
  logic [3:0]    cd_user;
  logic          arr_req;
  logic          arr_gnt;
  logic          arr_tag_en;
  logic          arr_data_en;
  logic [5:0]    arr_idx;
  logic [1:0]    arr_way;
  logic [83:0]   arr_tag_rdata;
  logic [511:0]  arr_data_rdata;
  logic [31:0]   wb_addr;
  logic          wb_hit;
  logic [511:0]  wb_data;
  logic          snoop_miss;

  dcache_snoop_responder dut (
    .clk(clk), .rst(rst),
    .ac_valid(ac_valid), .ac_ready(ac_ready), .ac_addr(ac_addr), .ac_user(ac_user),
    .cd_valid(cd_valid), .cd_ready(cd_ready), .cd_data(cd_data), .cd_last(cd_last), .cd_user(cd_user),
    .arr_req(arr_req), .arr_gnt(arr_gnt), .arr_tag_en(arr_tag_en), .arr_data_en(arr_data_en),
    .arr_idx(arr_idx), .arr_way(arr_way), .arr_tag_rdata(arr_tag_rdata), .arr_data_rdata(arr_data_rdata),
    .wb_addr(wb_addr), .wb_hit(wb_hit), .wb_data(wb_data), .snoop_miss(snoop_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Per-snoop observations gathered by do_snoop.
  logic [63:0] got_data [16];
  logic        got_last [16];
  logic [3:0]  got_user [16];
  int          got_cnt, first_k, miss_cnt, early_rdy, stall_err, req_err, timeout, data_req_seen;
  logic [5:0]  tag_idx;
  logic [1:0]  data_way;
  logic [511:0] exp_line;

  task automatic set_tags_hit_way2;
    arr_tag_rdata = '0;
    arr_tag_rdata[0*21 +: 21] = {20'h12345, 1'b1};
    arr_tag_rdata[1*21 +: 21] = {20'h80001, 1'b0};
    arr_tag_rdata[2*21 +: 21] = {20'h80001, 1'b1};
    arr_tag_rdata[3*21 +: 21] = {20'h80001, 1'b1};
  endtask

  task automatic set_arr_line;
    for (int i = 0; i < 8; i++) arr_data_rdata[i*64 +: 64] = 64'hC0DE_0000_0000_0000 + 64'(i) * 64'h0101;
  endtask

  task automatic do_snoop(input logic [31:0] addr, input logic [3:0] user, input bit toggle,
                          input int tag_dly, input int data_dly, input int stop_after);
    int k, tw, dw, vcnt;
    bit done, pv_stall, req_seen, req_te;
    logic [63:0] pv_data;
    logic pv_last;
    logic [3:0] pv_user;
    logic [5:0] req_idx;
    logic [1:0] req_way;
    got_cnt = 0; first_k = -1; miss_cnt = 0; early_rdy = 0; stall_err = 0; req_err = 0;
    timeout = 0; data_req_seen = 0; tag_idx = '0; data_way = '0;
    tw = 0; dw = 0; vcnt = 0; done = 0; pv_stall = 0; req_seen = 0; req_te = 0;
    pv_data = '0; pv_last = 0; pv_user = '0; req_idx = '0; req_way = '0;
    ac_addr = addr; ac_user = user; ac_valid = 1'b1;
    @(posedge clk); #1;
    ac_valid = 1'b0;
    k = 1;
    while (!done) begin
      if (k > 300) begin timeout = 1; break; end
      if (snoop_miss) miss_cnt++;
      if (ac_ready) early_rdy++;
      arr_gnt = 1'b0;
      if (arr_req) begin
        if (req_seen && (arr_idx !== req_idx || arr_way !== req_way || arr_tag_en !== req_te)) req_err++;
        if (arr_tag_en && arr_data_en) req_err++;
        req_seen = 1; req_idx = arr_idx; req_way = arr_way; req_te = arr_tag_en;
        if (arr_tag_en) begin tag_idx = arr_idx; if (tw < tag_dly) tw++; else arr_gnt = 1'b1; end
        if (arr_data_en) begin data_req_seen = 1; data_way = arr_way; if (dw < data_dly) dw++; else arr_gnt = 1'b1; end
      end else begin
        req_seen = 0;
      end
      cd_ready = toggle ? (vcnt % 3 == 0) : 1'b1;
      if (cd_valid) begin
        if (first_k < 0) first_k = k;
        if (pv_stall && (cd_data !== pv_data || cd_last !== pv_last || cd_user !== pv_user)) stall_err++;
        vcnt++;
        if (cd_ready) begin
          if (got_cnt < 16) begin
            got_data[got_cnt] = cd_data; got_last[got_cnt] = cd_last; got_user[got_cnt] = cd_user;
          end
          got_cnt++;
          if (cd_last || got_cnt == stop_after) done = 1;
        end
        pv_stall = !cd_ready; pv_data = cd_data; pv_last = cd_last; pv_user = cd_user;
      end else begin
        pv_stall = 0;
      end
      if (!done) begin @(posedge clk); #1; k++; end
    end
    @(posedge clk); #1;
    arr_gnt = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (ac_ready !== 1'b1) $display("FAIL reset_ac_ready got %b want 1", ac_ready); else n_pass++;
    n_total++; if (cd_valid !== 1'b0) $display("FAIL reset_cd_valid got %b want 0", cd_valid); else n_pass++;
    n_total++; if (cd_last !== 1'b0) $display("FAIL reset_cd_last got %b want 0", cd_last); else n_pass++;
    n_total++; if (arr_req !== 1'b0) $display("FAIL reset_arr_req got %b want 0", arr_req); else n_pass++;
    n_total++; if (snoop_miss !== 1'b0) $display("FAIL reset_snoop_miss got %b want 0", snoop_miss); else n_pass++;
    n_total++; if (cd_data !== 64'h0 || cd_user !== 4'h0 || wb_addr !== 32'h0)
      $display("FAIL reset_data got %h/%h/%h want 0/0/0", cd_data, cd_user, wb_addr); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    n_total++; if (ac_ready !== 1'b1) $display("FAIL idle_ac_ready got %b want 1", ac_ready); else n_pass++;
  endtask

  task automatic test_array_hit;
    set_tags_hit_way2();
    set_arr_line();
    wb_hit = 1'b1;
    for (int i = 0; i < 8; i++) wb_data[i*64 +: 64] = 64'hBAD0_0000_0000_0000 + 64'(i);
    do_snoop(32'h8000_1040, 4'hC, 0, 0, 0, 99);
    n_total++; if (timeout != 0) $display("FAIL hit_timeout got %0d want 0", timeout); else n_pass++;
    n_total++; if (wb_addr !== 32'h8000_1040) $display("FAIL hit_wb_addr got %h want 80001040", wb_addr); else n_pass++;
    n_total++; if (tag_idx !== 6'd1) $display("FAIL hit_arr_idx got %0d want 1", tag_idx); else n_pass++;
    n_total++; if (data_way !== 2'd2 || data_req_seen != 1) $display("FAIL hit_arr_way got %0d/%0d want 2/1", data_way, data_req_seen); else n_pass++;
    n_total++; if (first_k != 5) $display("FAIL hit_latency got %0d want 5", first_k); else n_pass++;
    n_total++; if (got_cnt != 8) $display("FAIL hit_beats got %0d want 8", got_cnt); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (got_data[i] !== arr_data_rdata[i*64 +: 64] || got_last[i] !== (i == 7) || got_user[i] !== 4'hC)
        $display("FAIL hit_beat%0d got %h/%b/%h want %h/%b/c", i, got_data[i], got_last[i], got_user[i],
                 arr_data_rdata[i*64 +: 64], (i == 7));
      else n_pass++;
    end
    n_total++; if (miss_cnt != 0 || req_err != 0) $display("FAIL hit_miss_req got %0d/%0d want 0/0", miss_cnt, req_err); else n_pass++;
    n_total++; if (ac_ready !== 1'b1 || cd_valid !== 1'b0) $display("FAIL hit_done got %b/%b want 1/0", ac_ready, cd_valid); else n_pass++;
  endtask

  task automatic test_wb_hit;
    arr_tag_rdata = '0;
    wb_hit = 1'b1;
    for (int i = 0; i < 8; i++) wb_data[i*64 +: 64] = 64'(i + 1) * 64'h11;
    do_snoop(32'h0000_2380, 4'h3, 0, 0, 0, 99);
    n_total++; if (timeout != 0 || got_cnt != 8) $display("FAIL wb_beats got %0d/%0d want 0/8", timeout, got_cnt); else n_pass++;
    n_total++; if (data_req_seen != 0) $display("FAIL wb_no_data_req got %0d want 0", data_req_seen); else n_pass++;
    n_total++; if (first_k != 3) $display("FAIL wb_latency got %0d want 3", first_k); else n_pass++;
    n_total++; if (miss_cnt != 0) $display("FAIL wb_snoop_miss got %0d want 0", miss_cnt); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (got_data[i] !== 64'(i + 1) * 64'h11 || got_user[i] !== 4'h3)
        $display("FAIL wb_beat%0d got %h/%h want %h/3", i, got_data[i], got_user[i], 64'(i + 1) * 64'h11);
      else n_pass++;
    end
  endtask

  task automatic test_miss;
    arr_tag_rdata = '0;
    arr_tag_rdata[0*21 +: 21] = {20'h00004, 1'b0};
    wb_hit = 1'b0;
    do_snoop(32'h0000_4000, 4'h5, 0, 0, 0, 99);
    n_total++; if (miss_cnt != 1) $display("FAIL miss_pulse got %0d want 1", miss_cnt); else n_pass++;
    n_total++; if (first_k != 3 || got_cnt != 8) $display("FAIL miss_beats got %0d/%0d want 3/8", first_k, got_cnt); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (got_data[i] !== 64'h0 || got_last[i] !== (i == 7))
        $display("FAIL miss_beat%0d got %h/%b want 0/%b", i, got_data[i], got_last[i], (i == 7));
      else n_pass++;
    end
    n_total++; if (ac_ready !== 1'b1 || snoop_miss !== 1'b0) $display("FAIL miss_idle got %b/%b want 1/0", ac_ready, snoop_miss); else n_pass++;
  endtask

  task automatic test_gnt_stall;
    set_tags_hit_way2();
    wb_hit = 1'b0;
    do_snoop(32'h8000_1040, 4'h9, 0, 3, 2, 99);
    n_total++; if (first_k != 10) $display("FAIL stall_latency got %0d want 10", first_k); else n_pass++;
    n_total++; if (req_err != 0) $display("FAIL stall_req_stable got %0d want 0", req_err); else n_pass++;
    n_total++; if (data_way !== 2'd2 || got_cnt != 8) $display("FAIL stall_way got %0d/%0d want 2/8", data_way, got_cnt); else n_pass++;
    n_total++; if (got_data[7] !== arr_data_rdata[7*64 +: 64]) $display("FAIL stall_last_data got %h want %h", got_data[7], arr_data_rdata[7*64 +: 64]); else n_pass++;
  endtask

  task automatic test_back_pressure;
    set_tags_hit_way2();
    wb_hit = 1'b0;
    do_snoop(32'h8000_1040, 4'hA, 1, 0, 0, 99);
    n_total++; if (stall_err != 0) $display("FAIL bp_stable got %0d want 0", stall_err); else n_pass++;
    n_total++; if (got_cnt != 8) $display("FAIL bp_beats got %0d want 8", got_cnt); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (got_data[i] !== arr_data_rdata[i*64 +: 64] || got_last[i] !== (i == 7))
        $display("FAIL bp_beat%0d got %h/%b want %h/%b", i, got_data[i], got_last[i], arr_data_rdata[i*64 +: 64], (i == 7));
      else n_pass++;
    end
    n_total++; if (early_rdy != 0) $display("FAIL bp_ac_ready_early got %0d want 0", early_rdy); else n_pass++;
    n_total++; if (ac_ready !== 1'b1) $display("FAIL bp_ac_ready_after got %b want 1", ac_ready); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int seen;
    arr_tag_rdata = '0;
    wb_hit = 1'b1;
    for (int i = 0; i < 8; i++) wb_data[i*64 +: 64] = 64'h7700 + 64'(i);
    do_snoop(32'h0000_0100, 4'h6, 0, 0, 0, 4);
    cd_ready = 1'b0;
    n_total++; if (got_cnt != 4 || cd_valid !== 1'b1) $display("FAIL rmid_pre got %0d/%b want 4/1", got_cnt, cd_valid); else n_pass++;
    rst = 1'b1;
    #2;
    n_total++; if (cd_valid !== 1'b0 || ac_ready !== 1'b1) $display("FAIL rmid_abort got %b/%b want 0/1", cd_valid, ac_ready); else n_pass++;
    n_total++; if (cd_last !== 1'b0 || cd_data !== 64'h0) $display("FAIL rmid_clear got %b/%h want 0/0", cd_last, cd_data); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (cd_valid) seen++;
    end
    n_total++; if (seen != 0) $display("FAIL rmid_no_resume got %0d want 0", seen); else n_pass++;
    for (int i = 0; i < 8; i++) wb_data[i*64 +: 64] = 64'h5500 + 64'(i);
    do_snoop(32'h0000_0140, 4'h2, 0, 0, 0, 99);
    n_total++; if (got_cnt != 8 || got_data[0] !== 64'h5500) $display("FAIL rmid_restart got %0d/%h want 8/5500", got_cnt, got_data[0]); else n_pass++;
    n_total++; if (got_data[3] !== 64'h5503 || got_last[7] !== 1'b1) $display("FAIL rmid_order got %h/%b want 5503/1", got_data[3], got_last[7]); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    ac_valid = 1'b0; ac_addr = '0; ac_user = '0;
    cd_ready = 1'b1; arr_gnt = 1'b0;
    arr_tag_rdata = '0; arr_data_rdata = '0;
    wb_hit = 1'b0; wb_data = '0;
    exp_line = '0;
    test_reset();
    test_array_hit();
    test_wb_hit();
    test_miss();
    test_gnt_stall();
    test_back_pressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
